// File: rtl/boot_pkg.sv
// Shared definitions for the boot memory loader.
//   boot_state_e : frame parser state encoding
//   SYNC_BYTE    : frame start marker
//   HDR_BYTES    : header length after sync (start addr LE, word count LE)
//   BYTE_CNT_W   : payload byte counter width (4 * 65535 bytes max)
//   lane_strb()  : one-hot byte strobe for a 32-bit word lane
`timescale 1ns/1ps
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4
  } boot_state_e;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         HDR_BYTES  = 4;
  localparam int         BYTE_CNT_W = 18;

  function automatic logic [3:0] lane_strb(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/boot_mem_loader.sv
// Boot memory loader: parses a byte-stream frame and writes its payload into
// one port of the dual-port boot memory, one byte lane per write.
//
// Frame: A5 | addr_lo addr_hi | cnt_lo cnt_hi | 4*N payload bytes | checksum
// Checksum is the XOR of every byte after sync, header included.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   s_valid/s_data  : incoming byte stream, s_ready is the handshake back
//   abort           : cancels the frame in progress (err=1, done pulses)
//   mem_en/mem_we   : memory enable / write enable (only high on a write)
//   mem_wstrb       : one-hot byte lane strobe
//   mem_addr        : word address, wraps modulo 2^ADDR_WIDTH
//   mem_din         : payload byte replicated on all lanes
//   busy            : frame in progress (HDR, DATA, CSUM)
//   done            : one-cycle pulse when a frame ends
//   err             : sticky checksum/abort error of the last frame
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | hunting for sync byte, everything else is dropped
// HDR   | collecting start address and word count (4 bytes)
// DATA  | streaming payload, one lane write per accepted byte
// CSUM  | comparing the trailing checksum byte
// DONE  | one-cycle frame end: done pulse, input stalled
`timescale 1ns/1ps
module boot_mem_loader
  import boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  input  logic [7:0]              s_data,
  output logic                    s_ready,
  input  logic                    abort,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] HDR_LAST = 2'(HDR_BYTES - 1);

  boot_state_e state_q, state_d;

  logic [1:0]            hdr_idx_q, hdr_idx_d;
  logic [7:0]            start_lo_q, start_lo_d;
  logic [7:0]            cnt_lo_q, cnt_lo_d;
  logic [7:0]            csum_q, csum_d;
  logic [BYTE_CNT_W-1:0] byte_rem_q, byte_rem_d;
  logic [ADDR_WIDTH-1:0] word_ptr_q, word_ptr_d;
  logic                  err_q, err_d;

  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [STRB_W-1:0]     mem_wstrb_q, mem_wstrb_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;

  logic       accept;
  logic       in_frame;
  logic       abort_hit;
  logic [1:0] lane;
  logic [15:0] n_words;

  assign s_ready   = (state_q != ST_DONE);
  assign accept    = s_valid && s_ready;
  assign in_frame  = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign abort_hit = abort && in_frame;
  // The remaining-byte counter starts at a multiple of 4, so the current
  // lane (k mod 4) is simply the two's complement of its low two bits.
  assign lane      = 2'd0 - byte_rem_q[1:0];
  assign n_words   = {s_data, cnt_lo_q};

  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    start_lo_d  = start_lo_q;
    cnt_lo_d    = cnt_lo_q;
    csum_d      = csum_q;
    byte_rem_d  = byte_rem_q;
    word_ptr_d  = word_ptr_q;
    err_d       = err_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wstrb_d = '0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;

    case (state_q)
      ST_IDLE: begin
        if (accept && (s_data == SYNC_BYTE)) begin
          state_d    = ST_HDR;
          hdr_idx_d  = 2'd0;
          csum_d     = 8'h00;
          err_d      = 1'b0;
          byte_rem_d = '0;
        end
      end

      ST_HDR: begin
        if (abort_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (accept) begin
          csum_d    = csum_q ^ s_data;
          hdr_idx_d = hdr_idx_q + 2'd1;
          case (hdr_idx_q)
            2'd0: start_lo_d = s_data;
            // Start address bits above ADDR_WIDTH are dropped here, which
            // is what makes the write address wrap.
            2'd1: word_ptr_d = ADDR_WIDTH'({s_data, start_lo_q});
            2'd2: cnt_lo_d   = s_data;
            default: begin
              byte_rem_d = {n_words, 2'b00};
              state_d    = (n_words == 16'd0) ? ST_CSUM : ST_DATA;
            end
          endcase
          if (hdr_idx_q == HDR_LAST) begin
            hdr_idx_d = 2'd0;
          end
        end
      end

      ST_DATA: begin
        if (abort_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (accept) begin
          csum_d      = csum_q ^ s_data;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_wstrb_d = STRB_W'(lane_strb(lane));
          mem_addr_d  = word_ptr_q;
          mem_din_d   = {STRB_W{s_data}};
          byte_rem_d  = byte_rem_q - 1'b1;
          if (lane == 2'd3) begin
            word_ptr_d = word_ptr_q + 1'b1;
          end
          if (byte_rem_q == BYTE_CNT_W'(1)) begin
            state_d = ST_CSUM;
          end
        end
      end

      ST_CSUM: begin
        if (abort_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (accept) begin
          if (s_data != csum_q) begin
            err_d = 1'b1;
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hdr_idx_q   <= '0;
      start_lo_q  <= '0;
      cnt_lo_q    <= '0;
      csum_q      <= '0;
      byte_rem_q  <= '0;
      word_ptr_q  <= '0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      start_lo_q  <= start_lo_d;
      cnt_lo_q    <= cnt_lo_d;
      csum_q      <= csum_d;
      byte_rem_q  <= byte_rem_d;
      word_ptr_q  <= word_ptr_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign busy      = in_frame;
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_boot_mem_loader.sv
// Testbench for boot_mem_loader: directed frame table, reset-in-DATA
// sequence and randomized frames against a write-list reference model.
`timescale 1ns/1ps
module tb_boot_mem_loader;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_ready;
  logic          abort = 1'b0;
  logic          mem_en, mem_we;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          busy, done, err;

  always #5 clk = ~clk;

  boot_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .abort(abort), .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    strb;
    logic [31:0]   din;
  } wr_t;

  typedef struct {
    logic [15:0] start;
    int          n;
    int          pat;       // 0: payload 01,02,.. ; 1: random payload
    logic [7:0]  flip;      // XORed into the checksum byte
    int          abort_at;  // post-sync byte index carrying abort, -1 none
    bit          pre_junk;  // send 00,FF before the sync byte
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  wr_t         exp_wr_q[$];
  wr_t         mon_e;
  logic [31:0] dut_mem [0:(1<<AW)-1];
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  bit          gaps_en = 1'b0;
  vec_t        vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Observe the memory port on the falling edge: every write must match the
  // head of the expected list; idle cycles must keep we/strobes low.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_en) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h strb 0x%0h din 0x%0h, expected no write at %0t",
                   mem_addr, mem_wstrb, mem_din, $time);
        end else begin
          mon_e = exp_wr_q.pop_front();
          chk("write", {mem_we, mem_wstrb, mem_addr, mem_din}, {1'b1, mon_e.strb, mon_e.addr, mon_e.din});
        end
        for (int l = 0; l < 4; l++)
          if (mem_wstrb[l]) dut_mem[mem_addr][8*l +: 8] = mem_din[8*l +: 8];
        wr_cnt++;
      end else begin
        chk("idle_strobes", {59'd0, mem_we, mem_wstrb}, 64'd0);
      end
      if (done) done_cnt++;
    end
  end

  // All driving tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    if (gaps_en) begin
      while ($urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1;
    s_data  = b;
    guard   = 0;
    while (!s_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_wait", {63'd0, s_ready}, 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_abort_byte(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    abort   = 1'b1;
    @(posedge clk); #1;
    abort   = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] start, input int n, input int pat,
                           input logic [7:0] flip, input int abort_at, input bit pre_junk,
                           input bit exp_err, input int exp_writes);
    logic [7:0] bq[$];
    logic [7:0] b;
    logic [7:0] cs;
    wr_t        e;
    int         done0, wr0, guard;
    done0 = done_cnt;
    wr0   = wr_cnt;
    if (pre_junk) begin
      send_byte(8'h00);
      send_byte(8'hFF);
      chk("junk_busy", {63'd0, busy}, 64'd0);
    end
    bq.push_back(start[7:0]);
    bq.push_back(start[15:8]);
    bq.push_back(8'(n));
    bq.push_back(8'(n >> 8));
    for (int k = 0; k < 4*n; k++) begin
      b = (pat == 0) ? 8'(k + 1) : 8'($urandom);
      bq.push_back(b);
      if (abort_at < 0 || (4 + k) < abort_at) begin
        e.addr = AW'((int'(start) + k/4) % (1 << AW));
        e.strb = 4'(1 << (k % 4));
        e.din  = {4{b}};
        exp_wr_q.push_back(e);
      end
    end
    cs = 8'h00;
    foreach (bq[i]) cs = cs ^ bq[i];
    bq.push_back(cs ^ flip);

    send_byte(8'hA5);
    chk("busy_after_sync", {63'd0, busy}, 64'd1);
    for (int i = 0; i < bq.size(); i++) begin
      if (i == abort_at) begin
        send_abort_byte(bq[i]);
        break;
      end
      send_byte(bq[i]);
    end

    guard = 0;
    while (done_cnt == done0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("done_pulses", 64'(done_cnt - done0), 64'd1);
    chk("err", {63'd0, err}, {63'd0, exp_err});
    chk("busy_end", {63'd0, busy}, 64'd0);
    chk("write_count", 64'(wr_cnt - wr0), 64'(exp_writes));
    chk("writes_pending", 64'(exp_wr_q.size()), 64'd0);
    exp_wr_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {63'd0, s_ready}, 64'd1);
    chk({tag, "_flags"}, {60'd0, busy, done, err, mem_en}, 64'd0);
    chk({tag, "_mem"}, {mem_we, mem_wstrb, mem_addr, mem_din}, 64'd0);
  endtask

  initial begin : main
    logic [7:0] b;
    logic [15:0] r_start;
    logic [7:0]  r_flip;
    int          r_n, r_abort, r_wr;
    bit          r_err;

    for (int a = 0; a < (1 << AW); a++) dut_mem[a] = 32'h0;

    vecs[0] = '{16'h0010, 2, 0, 8'h00, -1, 1'b0, 1'b0, 8};
    vecs[1] = '{16'h0010, 2, 0, 8'hFF, -1, 1'b0, 1'b1, 8};
    vecs[2] = '{16'h0123, 0, 1, 8'h00, -1, 1'b1, 1'b0, 0};
    vecs[3] = '{16'h03FF, 2, 0, 8'h00, -1, 1'b0, 1'b0, 8};
    vecs[4] = '{16'h0040, 4, 1, 8'h00,  6, 1'b0, 1'b1, 2};
    vecs[5] = '{16'hFC05, 3, 1, 8'h00, -1, 1'b0, 1'b0, 12};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("after_reset");

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].start, vecs[v].n, vecs[v].pat, vecs[v].flip, vecs[v].abort_at,
                vecs[v].pre_junk, vecs[v].exp_err, vecs[v].exp_writes);
      if (v == 0) begin
        chk("word_0x10", {32'd0, dut_mem[16]}, 64'h0403_0201);
        chk("word_0x11", {32'd0, dut_mem[17]}, 64'h0807_0605);
      end
      if (v == 3) begin
        chk("word_0x3ff", {32'd0, dut_mem[10'h3FF]}, 64'h0403_0201);
        chk("word_wrap_0", {32'd0, dut_mem[0]}, 64'h0807_0605);
      end
    end

    // Abort while idle must not start or end a frame.
    r_wr  = done_cnt;
    abort = 1'b1;
    send_byte(8'h3C);
    abort = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("idle_abort_busy", {63'd0, busy}, 64'd0);
    chk("idle_abort_done", 64'(done_cnt - r_wr), 64'd0);

    // Reset in the middle of DATA with back-pressure.
    gaps_en = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h06);
    send_byte(8'h00);
    for (int k = 0; k < 5; k++) begin
      wr_t e;
      b      = 8'($urandom);
      e.addr = AW'(10'h200 + k/4);
      e.strb = 4'(1 << (k % 4));
      e.din  = {4{b}};
      exp_wr_q.push_back(e);
      send_byte(b);
    end
    chk("busy_mid_data", {63'd0, busy}, 64'd1);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    exp_wr_q.delete();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("post_mid_reset");
    run_frame(16'h0210, 3, 1, 8'h00, -1, 1'b0, 1'b0, 12);

    // Randomized frames; the model derives writes, count and err from the
    // frame rules alone.
    for (int f = 0; f < 25; f++) begin
      gaps_en = 1'($urandom_range(0, 1));
      r_start = 16'($urandom);
      r_n     = $urandom_range(0, 8);
      r_flip  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      r_abort = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4 + 4*r_n)) : -1;
      r_err   = (r_flip != 8'h00) || (r_abort >= 0);
      if (r_abort < 0)          r_wr = 4*r_n;
      else if (r_abort <= 4)    r_wr = 0;
      else                      r_wr = (r_abort - 4 < 4*r_n) ? r_abort - 4 : 4*r_n;
      run_frame(r_start, r_n, 1, r_flip, r_abort, 1'($urandom_range(0, 1)), r_err, r_wr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
